// File: rtl/mac_accumulator_if.sv
// Bundle of the product stream, the attached prefix-adder port and the result port of mac_accumulator.
// The accumulator connects to the slave modport. The environment (upstream, adder, consumer) connects to master.
interface mac_accumulator_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_prod;
    logic                  i_prod_valid;
    logic                  i_prod_last;
    logic                  o_prod_ready;

    logic [DATA_WIDTH-1:0] o_adder_a;
    logic [DATA_WIDTH-1:0] o_adder_b;
    logic                  o_adder_valid;
    logic [DATA_WIDTH-1:0] i_adder_val;
    logic                  i_adder_valid;

    logic [DATA_WIDTH-1:0] o_sum;
    logic                  o_sum_valid;
    logic                  o_busy;

    modport slave (
        input  i_prod, i_prod_valid, i_prod_last, i_adder_val, i_adder_valid,
        output o_prod_ready, o_adder_a, o_adder_b, o_adder_valid, o_sum, o_sum_valid, o_busy
    );

    modport master (
        output i_prod, i_prod_valid, i_prod_last, i_adder_val, i_adder_valid,
        input  o_prod_ready, o_adder_a, o_adder_b, o_adder_valid, o_sum, o_sum_valid, o_busy
    );
endinterface

// File: rtl/mac_accumulator.sv
// Streams products through an external ADDER_LAT-stage adder as ADDER_LAT interleaved partial sums.
// At vector end it drains the partial sums into a bank and folds them into one modular sum.
module mac_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDER_LAT  = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mac_accumulator_if.slave bus
);
    localparam int SLOT_W = $clog2(ADDER_LAT);
    localparam int CNT_W  = $clog2(ADDER_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_COLLECT,
        S_FOLD,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] bank_q [ADDER_LAT];
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [SLOT_W-1:0]     ret_slot_q;
    logic [SLOT_W-1:0]     fold_k_q;
    logic [SLOT_W-1:0]     fold_next;
    logic [DATA_WIDTH-1:0] sum_q;

    logic                  prod_ready;
    logic                  accept;
    logic                  ret;
    logic                  issue;
    logic [DATA_WIDTH-1:0] adder_a;
    logic [DATA_WIDTH-1:0] adder_b;
    logic                  bank_clear;
    logic                  bank_wr;
    logic                  sum_load;
    logic                  fold_step;

    assign fold_next = fold_k_q + SLOT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        issue      = 1'b0;
        adder_a    = '0;
        adder_b    = '0;
        bank_clear = 1'b0;
        bank_wr    = 1'b0;
        sum_load   = 1'b0;
        fold_step  = 1'b0;
        prod_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
        accept     = bus.i_prod_valid && prod_ready;
        ret        = bus.i_adder_valid &&
                     ((state_q == S_ACCUM) || (state_q == S_COLLECT) || (state_q == S_FOLD));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    issue      = 1'b1;
                    adder_a    = bus.i_prod;
                    bank_clear = 1'b1;
                    state_d    = bus.i_prod_last ? S_COLLECT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // Bubble cycles still issue, so returning partial sums recirculate unchanged.
                issue   = 1'b1;
                adder_a = accept ? bus.i_prod : '0;
                adder_b = bus.i_adder_valid ? bus.i_adder_val : '0;
                if (accept && bus.i_prod_last) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.i_adder_valid) begin
                    bank_wr = 1'b1;
                    if (inflight_q == CNT_W'(1)) begin
                        state_d = S_FOLD;
                    end
                end
            end
            S_FOLD: begin
                if (fold_k_q == '0) begin
                    issue     = 1'b1;
                    adder_a   = bank_q[0];
                    adder_b   = bank_q[1];
                    fold_step = 1'b1;
                end else if (bus.i_adder_valid) begin
                    if (fold_k_q == SLOT_W'(ADDER_LAT - 1)) begin
                        sum_load = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        issue     = 1'b1;
                        adder_a   = bus.i_adder_val;
                        adder_b   = bank_q[fold_next];
                        fold_step = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case ({issue, ret})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        if (bank_clear) begin
            inflight_d = CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state_q    <= S_IDLE;
            inflight_q <= '0;
            ret_slot_q <= '0;
            fold_k_q   <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            if (bank_clear) begin
                ret_slot_q <= '0;
                fold_k_q   <= '0;
            end else begin
                if (bank_wr) begin
                    ret_slot_q <= (ret_slot_q == SLOT_W'(ADDER_LAT - 1)) ? '0 : ret_slot_q + SLOT_W'(1);
                end
                if (fold_step) begin
                    fold_k_q <= fold_next;
                end
            end
            if (sum_load) begin
                sum_q <= bus.i_adder_val;
            end
        end
    end

    // NOTE: the bank is reset and cleared because slots never written must read as 0 during FOLD.
    always_ff @(posedge i_clk) begin
        if (i_rst || bank_clear) begin
            for (int i = 0; i < ADDER_LAT; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_wr) begin
            bank_q[ret_slot_q] <= bus.i_adder_val;
        end
    end

    assign bus.o_prod_ready  = prod_ready;
    assign bus.o_adder_a     = adder_a;
    assign bus.o_adder_b     = adder_b;
    assign bus.o_adder_valid = issue;
    assign bus.o_sum         = sum_q;
    assign bus.o_sum_valid   = (state_q == S_DONE);
    assign bus.o_busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: a behavioural 7-stage adder, directed and random vectors.
// A scoreboard predicts sums, pulse timing, ready and busy from the beats that were handed over.
module tb_mac_accumulator;
    localparam int L   = 7;
    localparam int LAT = 2 + L * L;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   cyc   = 0;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    mac_accumulator_if #(.DATA_WIDTH(32)) mac_if ();

    mac_accumulator #(.DATA_WIDTH(32), .ADDER_LAT(L)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (mac_if)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural pipelined adder; its reset shares i_rst with the accumulator.
    logic [L-1:0] add_v;
    logic [31:0]  add_d [L];
    always @(posedge i_clk) begin
        if (i_rst) begin
            add_v <= '0;
            for (int i = 0; i < L; i++) add_d[i] <= '0;
        end else begin
            add_v    <= {add_v[L-2:0], mac_if.o_adder_valid};
            add_d[0] <= mac_if.o_adder_a + mac_if.o_adder_b;
            for (int i = 1; i < L; i++) add_d[i] <= add_d[i-1];
        end
    end
    assign mac_if.i_adder_valid = add_v[L-1];
    assign mac_if.i_adder_val   = add_d[L-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: sum of handed-over beats per vector, pulse due LAT cycles after the last beat.
    typedef struct {
        logic [31:0] sum;
        int          due;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] acc;
    logic [31:0] held;
    bit          open;
    int          drain_end;

    initial begin
        bit exp_ready, exp_busy, exp_pulse;
        acc = '0; held = '0; open = 1'b0; drain_end = -1;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                exp_q.delete();
                acc = '0; held = '0; open = 1'b0; drain_end = -1;
            end else begin
                exp_ready = !(cyc <= drain_end);
                exp_busy  = open || (cyc <= drain_end);
                exp_pulse = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                check("prod_ready", {31'b0, mac_if.o_prod_ready}, {31'b0, exp_ready});
                check("busy", {31'b0, mac_if.o_busy}, {31'b0, exp_busy});
                check("sum_valid", {31'b0, mac_if.o_sum_valid}, {31'b0, exp_pulse});
                if (exp_pulse) begin
                    held = exp_q[0].sum;
                    exp_q.pop_front();
                end
                check("sum", mac_if.o_sum, held);
                if (mac_if.i_prod_valid && exp_ready) begin
                    acc  = acc + mac_if.i_prod;
                    open = 1'b1;
                    if (mac_if.i_prod_last) begin
                        exp_q.push_back('{sum: acc, due: cyc + LAT});
                        drain_end = cyc + LAT;
                        open      = 1'b0;
                        acc       = '0;
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        mac_if.i_prod_valid = 1'b0;
        mac_if.i_prod       = $urandom;
        mac_if.i_prod_last  = 1'($urandom);
    endtask

    task automatic send_vector(input logic [31:0] beats[$], input int gap_lo, input int gap_hi,
                               input bit with_last);
        for (int b = 0; b < beats.size(); b++) begin
            int  gap;
            int  waited;
            bit  took;
            gap = $urandom_range(gap_hi, gap_lo);
            repeat (gap) begin
                idle_inputs();
                @(posedge i_clk); #1;
            end
            mac_if.i_prod       = beats[b];
            mac_if.i_prod_last  = with_last && (b == beats.size() - 1);
            mac_if.i_prod_valid = 1'b1;
            waited = 0;
            took   = 1'b0;
            while (!took && waited < 200) begin
                @(negedge i_clk);
                took = mac_if.o_prod_ready;
                @(posedge i_clk); #1;
                waited++;
            end
            if (!took) check("accept_wait", {31'b0, took}, 32'd1);
            idle_inputs();
        end
    endtask

    task automatic wait_idle();
        int  waited;
        bit  busy;
        waited = 0;
        busy   = 1'b1;
        while (busy && waited < 200) begin
            @(negedge i_clk);
            busy = mac_if.o_busy;
            waited++;
        end
        check("idle_wait", {31'b0, busy}, 32'd0);
        @(posedge i_clk); #1;
    endtask

    task automatic pulse_reset(input int n);
        i_rst = 1'b1;
        idle_inputs();
        repeat (n) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v[$];
        idle_inputs();
        pulse_reset(3);
        repeat (3) @(posedge i_clk);
        #1;

        // Single beat, last in IDLE.
        v = '{32'd5};
        send_vector(v, 0, 0, 1'b1);
        wait_idle();

        // 1..10 back-to-back.
        v.delete();
        for (int i = 1; i <= 10; i++) v.push_back(32'(i));
        send_vector(v, 0, 0, 1'b1);
        wait_idle();

        // 20 beats of 3 with valid toggling.
        v.delete();
        for (int i = 0; i < 20; i++) v.push_back(32'd3);
        send_vector(v, 1, 1, 1'b1);
        wait_idle();

        // Modular wrap.
        v = '{32'hFFFF_FFFF, 32'h0000_0002};
        send_vector(v, 0, 0, 1'b1);
        wait_idle();

        // Reset mid-ACCUM, then a clean vector.
        v = '{32'd9, 32'd9, 32'd9, 32'd9};
        send_vector(v, 0, 0, 1'b0);
        pulse_reset(1);
        v = '{32'd7, 32'd8};
        send_vector(v, 0, 0, 1'b1);
        wait_idle();

        // Back-to-back vectors with upstream holding valid.
        v = '{32'd100, 32'd200};
        send_vector(v, 0, 0, 1'b1);
        v = '{32'd1};
        send_vector(v, 0, 0, 1'b1);
        wait_idle();

        // Random vectors, occasionally chained or aborted during drain/fold.
        for (int n = 0; n < 30; n++) begin
            int len;
            len = $urandom_range(20, 1);
            v.delete();
            for (int i = 0; i < len; i++) v.push_back($urandom);
            send_vector(v, 0, $urandom_range(3, 0), 1'b1);
            if (n % 10 == 7) begin
                repeat ($urandom_range(45, 1)) @(posedge i_clk);
                #1;
                pulse_reset(1);
            end else if ($urandom_range(3, 0) != 0) begin
                wait_idle();
            end
        end
        wait_idle();
        repeat (5) @(posedge i_clk);
        #1;
        check("pending_sums", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
